// File: rtl/rr_arbiter4_onehot.sv
// Four-requester round-robin arbiter with registered one-hot grant and enable.
// Feeds the 4:2 encoder directly, so at most one Y bit is ever high and en marks that it is.
module rr_arbiter4_onehot #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       en,
  output logic       Y3,
  output logic       Y2,
  output logic       Y1,
  output logic       Y0
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned PTR_W = 2;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [N_REQ-1:0]   r_y;
  logic               r_en;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [PTR_W-1:0]   r_last_ptr;
  logic [PTR_W-1:0]   r_owner;

  logic [N_REQ-1:0]   w_cand;
  logic               w_cand_any;
  logic [PTR_W-1:0]   w_start;
  logic [PTR_W-1:0]   w_pick;
  logic               w_keep;

  // Candidates exclude the current owner, so the same search serves idle pick,
  // release handoff and forced rotation.
  always_comb begin
    w_cand     = req & ~r_y;
    w_cand_any = |w_cand;
    w_start    = r_last_ptr + PTR_W'(1);
    w_pick     = w_start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_cand[PTR_W'(w_start + PTR_W'(i))]) begin
        w_pick = PTR_W'(w_start + PTR_W'(i));
      end
    end
    w_keep = (r_state == S_GRANT) && req[r_owner] &&
             ((r_hold_cnt != HOLD_LAST) || !w_cand_any);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_y        <= '0;
      r_en       <= 1'b0;
      r_hold_cnt <= '0;
      r_last_ptr <= PTR_W'(3);
      r_owner    <= '0;
    end else if (w_keep) begin
      if (r_hold_cnt != HOLD_LAST) begin
        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
      end
    end else if (w_cand_any) begin
      r_state    <= S_GRANT;
      r_y        <= N_REQ'(4'b0001 << w_pick);
      r_en       <= 1'b1;
      r_hold_cnt <= '0;
      r_last_ptr <= w_pick;
      r_owner    <= w_pick;
    end else begin
      // Release to idle keeps last_ptr so priority continues past the last winner.
      r_state    <= S_IDLE;
      r_y        <= '0;
      r_en       <= 1'b0;
      r_hold_cnt <= '0;
    end
  end

  assign en = r_en;
  assign Y3 = r_y[3];
  assign Y2 = r_y[2];
  assign Y1 = r_y[1];
  assign Y0 = r_y[0];

endmodule
